// File: rtl/fifo_serial.sv
// fifo_serial: serializes accepted pixel samples into two-word packets
// (coordinate word, then pixel word) for a downstream write-strobe FIFO.
// Latency: 1 cycle from acceptance to the first fifo_wrreq; 2 words per packet.
// Backpressure: fifo_full stalls the sender in place. img_out_rdy drops
// while the waiting-packet slot is occupied.
//
// Ports:
//   clk, reset                 single clock, asynchronous active-high reset
//   img_out_x/y/left/right     sample fields, captured when img_out_val & img_out_rdy
//   img_out_val, img_out_rdy   upstream valid/ready handshake
//   fifo_full                  downstream FIFO cannot take a word this cycle
//   fifo_wrreq, fifo_data      write strobe and word for the downstream FIFO
//   pkt_count                  completed packets, wraps modulo 2^CNT_W
//   debug_out                  {nxt_valid, cur_valid, state[1:0], fifo_wrreq, fifo_full}
module fifo_serial #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [9:0]       img_out_x,
  input  logic [9:0]       img_out_y,
  input  logic [7:0]       img_out_left,
  input  logic [7:0]       img_out_right,
  input  logic             img_out_val,
  output logic             img_out_rdy,
  input  logic             fifo_full,
  output logic             fifo_wrreq,
  output logic [31:0]      fifo_data,
  output logic [CNT_W-1:0] pkt_count,
  output logic [5:0]       debug_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COORD = 2'd1,
    PIX   = 2'd2
  } state_t;

  typedef struct packed {
    logic [9:0] y;
    logic [9:0] x;
    logic [7:0] left;
    logic [7:0] right;
  } sample_t;

  state_t  state;
  state_t  state_nxt;

  // cur is the packet on the wire; nxt is the single waiting slot.
  sample_t cur_dat;
  sample_t nxt_dat;
  logic    cur_vld;
  logic    nxt_vld;

  sample_t in_dat;
  logic    accept;
  logic    pkt_done;

  assign in_dat.y     = img_out_y;
  assign in_dat.x     = img_out_x;
  assign in_dat.left  = img_out_left;
  assign in_dat.right = img_out_right;

  // Ready depends only on registered state, so there is no combinational
  // path from img_out_val or fifo_full to img_out_rdy.
  assign img_out_rdy = ~nxt_vld;
  assign accept      = img_out_val & img_out_rdy;

  // The second word of a packet leaving this edge.
  assign pkt_done = (state == PIX) & fifo_wrreq;

  //--------------------------------------------------------------------------
  // FSM: state register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  //--------------------------------------------------------------------------
  // FSM: next-state logic
  //--------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = COORD;
        end
      end
      COORD: begin
        if (fifo_wrreq) begin
          state_nxt = PIX;
        end
      end
      PIX: begin
        if (fifo_wrreq) begin
          // Either a waiting packet or a sample arriving this very edge keeps
          // the wire busy with no bubble; otherwise go quiet.
          if (nxt_vld || accept) begin
            state_nxt = COORD;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // FSM: outputs
  //--------------------------------------------------------------------------
  always_comb begin
    fifo_wrreq = 1'b0;
    fifo_data  = 32'h0000_0000;
    case (state)
      COORD: begin
        fifo_wrreq = ~fifo_full;
        fifo_data  = {1'b0, 5'b0_0000, cur_dat.y, 6'b00_0000, cur_dat.x};
      end
      PIX: begin
        fifo_wrreq = ~fifo_full;
        fifo_data  = {1'b1, 15'h0000, cur_dat.left, cur_dat.right};
      end
      default: begin
        fifo_wrreq = 1'b0;
        fifo_data  = 32'h0000_0000;
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // Packet buffer. Captured fields only change on a load, so upstream may
  // wiggle its inputs freely while a sample is held.
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_dat <= '0;
      cur_vld <= 1'b0;
      nxt_dat <= '0;
      nxt_vld <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (accept) begin
          cur_dat <= in_dat;
          cur_vld <= 1'b1;
        end
      end else if (pkt_done) begin
        // nxt_vld implies img_out_rdy was low, so no acceptance collides
        // with the nxt -> cur promotion.
        if (nxt_vld) begin
          cur_dat <= nxt_dat;
          nxt_vld <= 1'b0;
        end else if (accept) begin
          cur_dat <= in_dat;
        end else begin
          cur_vld <= 1'b0;
        end
      end else if (accept) begin
        nxt_dat <= in_dat;
        nxt_vld <= 1'b1;
      end
    end
  end

  //--------------------------------------------------------------------------
  // Completed-packet counter, wraps naturally at 2^CNT_W.
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_count <= '0;
    end else if (pkt_done) begin
      pkt_count <= pkt_count + CNT_W'(1);
    end
  end

  assign debug_out = {nxt_vld, cur_vld, state, fifo_wrreq, fifo_full};

endmodule

// File: tb/tb_fifo_serial.sv
// tb_fifo_serial: directed stimulus for fifo_serial with a queue-based packet
// model checked every cycle, plus literal expectations for the key scenarios.
// Two instances run in lockstep: default counter width and CNT_W=2.
module tb_fifo_serial;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  img_out_x, img_out_y;
  logic [7:0]  img_out_left, img_out_right;
  logic        img_out_val;
  logic        fifo_full;

  logic        img_out_rdy, fifo_wrreq;
  logic [31:0] fifo_data;
  logic [15:0] pkt_count;
  logic [5:0]  debug_out;

  logic        img_out_rdy2, fifo_wrreq2;
  logic [31:0] fifo_data2;
  logic [1:0]  pkt_count2;
  logic [5:0]  debug_out2;

  always #5 clk = ~clk;

  fifo_serial dut (
    .clk(clk), .reset(reset),
    .img_out_x(img_out_x), .img_out_y(img_out_y),
    .img_out_left(img_out_left), .img_out_right(img_out_right),
    .img_out_val(img_out_val), .img_out_rdy(img_out_rdy),
    .fifo_full(fifo_full), .fifo_wrreq(fifo_wrreq), .fifo_data(fifo_data),
    .pkt_count(pkt_count), .debug_out(debug_out)
  );

  fifo_serial #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset),
    .img_out_x(img_out_x), .img_out_y(img_out_y),
    .img_out_left(img_out_left), .img_out_right(img_out_right),
    .img_out_val(img_out_val), .img_out_rdy(img_out_rdy2),
    .fifo_full(fifo_full), .fifo_wrreq(fifo_wrreq2), .fifo_data(fifo_data2),
    .pkt_count(pkt_count2), .debug_out(debug_out2)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  //--------------------------------------------------------------------------
  // Model: a queue of whole packets not yet fully written, and which word of
  // the head packet is next. Ready while fewer than two packets are held.
  //--------------------------------------------------------------------------
  logic [63:0] mq[$];
  bit          mphase;
  int unsigned mcnt;

  always @(posedge clk or posedge reset) begin : m_upd
    bit wr;
    bit acc;
    if (reset) begin
      mq.delete();
      mphase = 1'b0;
      mcnt   = 0;
    end else begin
      wr  = (mq.size() > 0) && !fifo_full;
      acc = img_out_val && (mq.size() < 2);
      if (wr) begin
        if (mphase) begin
          void'(mq.pop_front());
          mphase = 1'b0;
          mcnt++;
        end else begin
          mphase = 1'b1;
        end
      end
      if (acc) begin
        mq.push_back({6'd0, img_out_y, 6'd0, img_out_x,
                      16'h8000, img_out_left, img_out_right});
      end
    end
  end

  // Written-word log and per-cycle strobe history for the directed checks.
  logic [31:0] wlog[$];
  bit          whist[$];

  always @(negedge clk) begin : cmp
    logic [63:0] head;
    logic [31:0] exp_data;
    bit          exp_wr;
    bit          exp_rdy;
    if (!reset) begin
      exp_rdy  = mq.size() < 2;
      exp_wr   = (mq.size() > 0) && !fifo_full;
      exp_data = 32'h0;
      if (mq.size() > 0) begin
        head     = mq[0];
        exp_data = mphase ? head[31:0] : head[63:32];
      end
      chk("rdy",        {31'd0, img_out_rdy}, {31'd0, exp_rdy});
      chk("wrreq",      {31'd0, fifo_wrreq},  {31'd0, exp_wr});
      chk("data",       fifo_data,            exp_data);
      chk("pkt_count",  {16'd0, pkt_count},   mcnt % 65536);
      chk("pkt_count2", {30'd0, pkt_count2},  mcnt % 4);
      chk("wrreq2",     {31'd0, fifo_wrreq2}, {31'd0, exp_wr});
      chk("dbg_valids", {30'd0, debug_out[5:4]},
          {30'd0, mq.size() >= 2, mq.size() >= 1});
      chk("dbg_wr_full", {30'd0, debug_out[1:0]}, {30'd0, exp_wr, fifo_full});
      if (fifo_wrreq) wlog.push_back(fifo_data);
      whist.push_back(fifo_wrreq);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  //--------------------------------------------------------------------------
  // Stimulus helpers
  //--------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a sample and hold it until the edge that accepts it. Leaves
  // img_out_val high so back-to-back offers need no gap.
  task automatic offer(input logic [9:0] x, input logic [9:0] y,
                       input logic [7:0] l, input logic [7:0] r);
    bit got;
    img_out_x = x; img_out_y = y; img_out_left = l; img_out_right = r;
    img_out_val = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = img_out_rdy;
      @(posedge clk);
      #1;
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL offer_timeout: sample x=%0d y=%0d never accepted", x, y);
    end
  endtask

  // Drop valid and scramble the fields to prove held samples are isolated.
  task automatic idle_in();
    img_out_val   = 1'b0;
    img_out_x     = 10'($urandom);
    img_out_y     = 10'($urandom);
    img_out_left  = 8'($urandom);
    img_out_right = 8'($urandom);
  endtask

  function automatic logic [31:0] logw(input int i);
    if (i < wlog.size()) return wlog[i];
    return 32'hDEAD_BEEF;
  endfunction

  int idx;
  int run;
  int max_run;

  initial begin
    reset = 1'b1;
    fifo_full = 1'b0;
    img_out_val = 1'b0;
    img_out_x = '0; img_out_y = '0; img_out_left = '0; img_out_right = '0;
    #2;
    chk("rst_rdy",   {31'd0, img_out_rdy}, 32'd1);
    chk("rst_wrreq", {31'd0, fifo_wrreq},  32'd0);
    chk("rst_data",  fifo_data,            32'd0);
    chk("rst_count", {16'd0, pkt_count},   32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Single sample, accepted on the first edge after reset release.
    idx = wlog.size();
    offer(10'd5, 10'd3, 8'hAA, 8'h55);
    idle_in();
    @(negedge clk);
    chk("single_wr1",   {31'd0, fifo_wrreq}, 32'd1);
    chk("single_coord", fifo_data, 32'h0003_0005);
    @(negedge clk);
    chk("single_wr2",   {31'd0, fifo_wrreq}, 32'd1);
    chk("single_pix",   fifo_data, 32'h8000_AA55);
    @(negedge clk);
    chk("single_wr3",   {31'd0, fifo_wrreq}, 32'd0);
    chk("single_idle",  {30'd0, debug_out[5:4]}, 32'd0);
    chk("single_count", {16'd0, pkt_count}, 32'd1);
    @(posedge clk);
    #1;

    // Back-to-back: four samples with valid held high.
    idx = whist.size();
    for (int i = 0; i < 4; i++) begin
      offer(10'(16 + i), 10'(32 + i), 8'(i), 8'(255 - i));
    end
    idle_in();
    step(8);
    run = 0;
    max_run = 0;
    for (int i = idx; i < whist.size(); i++) begin
      run = whist[i] ? run + 1 : 0;
      if (run > max_run) max_run = run;
    end
    chk("b2b_run",    max_run, 32'd8);
    chk("b2b_count",  {16'd0, pkt_count},  32'd5);
    chk("cnt2_wrap",  {30'd0, pkt_count2}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("b2b_bit31", {31'd0, logw(wlog.size() - 8 + i) >> 31}, 32'(i % 2));
    end

    // Stall during COORD for 5 cycles.
    idx = wlog.size();
    fifo_full = 1'b1;
    offer(10'd9, 10'd7, 8'h12, 8'h34);
    idle_in();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_wr",   {31'd0, fifo_wrreq}, 32'd0);
      chk("stall_data", fifo_data, 32'h0007_0009);
      @(posedge clk);
      #1;
      idle_in();
    end
    fifo_full = 1'b0;
    step(4);
    chk("stall_nwords", wlog.size() - idx, 32'd2);
    chk("stall_w0", logw(idx),     32'h0007_0009);
    chk("stall_w1", logw(idx + 1), 32'h8000_1234);

    // Full with three samples offered: two buffered, third waits upstream.
    idx = wlog.size();
    fifo_full = 1'b1;
    offer(10'd1, 10'd2, 8'h11, 8'h22);
    offer(10'd3, 10'd4, 8'h33, 8'h44);
    @(negedge clk);
    chk("full_rdy_low", {31'd0, img_out_rdy}, 32'd0);
    @(posedge clk);
    #1;
    fork
      offer(10'd5, 10'd6, 8'h55, 8'h66);
      begin
        step(4);
        fifo_full = 1'b0;
      end
    join
    idle_in();
    step(10);
    chk("order_n",  wlog.size() - idx, 32'd6);
    chk("order_w0", logw(idx),     32'h0002_0001);
    chk("order_w1", logw(idx + 1), 32'h8000_1122);
    chk("order_w2", logw(idx + 2), 32'h0004_0003);
    chk("order_w3", logw(idx + 3), 32'h8000_3344);
    chk("order_w4", logw(idx + 4), 32'h0006_0005);
    chk("order_w5", logw(idx + 5), 32'h8000_5566);

    // Asynchronous reset in PIX with the waiting slot full.
    offer(10'd8, 10'd8, 8'h01, 8'h02);
    offer(10'd9, 10'd9, 8'h03, 8'h04);
    idle_in();
    #1;
    chk("pre_rst_wr",  {31'd0, fifo_wrreq}, 32'd1);
    chk("pre_rst_rdy", {31'd0, img_out_rdy}, 32'd0);
    chk("pre_rst_pix", fifo_data >> 31, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("arst_wr",    {31'd0, fifo_wrreq}, 32'd0);
    chk("arst_rdy",   {31'd0, img_out_rdy}, 32'd1);
    chk("arst_data",  fifo_data, 32'd0);
    chk("arst_count", {16'd0, pkt_count}, 32'd0);
    step(2);
    reset = 1'b0;
    idx = wlog.size();
    offer(10'h3FF, 10'h155, 8'hF0, 8'h0F);
    idle_in();
    step(5);
    chk("post_rst_n",     wlog.size() - idx, 32'd2);
    chk("post_rst_coord", logw(idx),     32'h0155_03FF);
    chk("post_rst_pix",   logw(idx + 1), 32'h8000_F00F);
    chk("post_rst_count", {16'd0, pkt_count}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
